ux607_wake_debounce: RTL and testbench
======================================

UX607_WAKE_DEBOUNCE -- requirements
Module: ux607_wake_debounce

Interface
REQ-001 Parameter: CNT_W, default 16, width of the debounce threshold and counter.
REQ-002 Port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: io_d  input  1  deglitched, already-synchronised wake level from the upstream deglitch stage.
REQ-005 Port: io_cfg_en  input  1  block enable.
REQ-006 Port: io_cfg_thresh  input  CNT_W  required stable-cycle count minus one.
REQ-007 Port: io_cfg_rise_en  input  1  rising debounced edge sets pending.
REQ-008 Port: io_cfg_fall_en  input  1  falling debounced edge sets pending.
REQ-009 Port: io_clr  input  1  one-cycle clear of the pending flag.
REQ-010 Port: io_level  output  1  debounced level, registered.
REQ-011 Port: io_rise  output  1  one-cycle pulse on debounced 0->1, registered.
REQ-012 Port: io_fall  output  1  one-cycle pulse on debounced 1->0, registered.
REQ-013 Port: io_pend  output  1  sticky wake-pending flag.
REQ-014 Port: io_irq  output  1  io_pend AND io_cfg_en, combinational from registered io_pend.

Function
REQ-015 The FSM SHALL have four states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
REQ-016 STABLE_LO with io_d=1 SHALL go to CHK_HI and clear the counter; STABLE_HI with io_d=0 SHALL go to CHK_LO and clear the counter.
REQ-017 CHK_HI with io_d=0 SHALL return to STABLE_LO (bounce) with the counter cleared and no pulse; CHK_LO with io_d=1 SHALL return to STABLE_HI likewise.
REQ-018 CHK_x with io_d still at the new level and counter >= io_cfg_thresh SHALL commit: go to STABLE_x, update io_level, and pulse io_rise/io_fall the same cycle io_level changes.
REQ-019 Otherwise CHK_x SHALL increment the counter; the counter SHALL never exceed io_cfg_thresh+1 and SHALL never wrap.
REQ-020 Latency: io_level SHALL change exactly io_cfg_thresh+2 cycles after the first cycle io_d is sampled at the new level, provided io_d holds.
REQ-021 io_cfg_thresh SHALL be compared live; lowering it during CHK commits on the next cycle if counter >= new value.
REQ-022 io_cfg_en=0 SHALL force the FSM to the STABLE state matching io_level, clear the counter, suppress pulses, hold io_pend, and mask io_irq.
REQ-023 io_pend SHALL set on (io_rise AND io_cfg_rise_en) OR (io_fall AND io_cfg_fall_en), SHALL clear on io_clr, and set SHALL win over simultaneous clear.
REQ-024 io_rise and io_fall SHALL never both be high; neither SHALL be high for two consecutive cycles.

Reset
REQ-025 Asserting reset SHALL immediately force state STABLE_LO, counter 0, io_level 0, io_rise 0, io_fall 0, io_pend 0, and therefore io_irq 0.
REQ-026 Reset asserted mid-check SHALL discard the check; after deassertion, a held io_d=1 SHALL produce io_level=1 after the full io_cfg_thresh+2 cycles.

Structure
REQ-027 The FSM state encoding and the CNT_W default SHALL live in the shared package ux607_wake_pkg.
REQ-028 No sub-module SHALL be used; counter and FSM are inline, and the deglitch stage is instantiated by the parent, upstream of io_d.

Verification
REQ-029 thresh=3, en=1, io_d 0->1 held -> io_level=1 and io_rise=1 on cycle 5 after the first io_d=1 sample; io_pend=1 if rise_en=1.
REQ-030 thresh=4, io_d high 3 cycles then low -> io_level stays 0, no io_rise, io_pend unchanged.
REQ-031 io_pend=1 with io_clr=1 in the same cycle as a new io_fall and fall_en=1 -> io_pend stays 1; io_clr alone the next cycle -> io_pend=0.
REQ-032 thresh=100, 10 cycles into CHK_HI, thresh rewritten to 5 -> commit on the next cycle with io_rise.
REQ-033 Reset pulsed low asynchronously mid-CHK_HI with io_pend=1 -> all outputs 0 before the next clock edge; io_d held high -> io_level=1 exactly thresh+2 cycles after reset release.
REQ-034 en=0 during CHK_LO -> FSM returns to STABLE_HI, no io_fall, io_irq=0 while io_pend holds 1; en=1 -> io_irq=1.

Source files
------------

// File: rtl/ux607_wake_pkg.sv
// Shared definitions for the wake-pin debounce block.
// Holds the FSM state encoding and the default counter width.
package ux607_wake_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } wake_state_e;

endpackage

// File: rtl/ux607_wake_debounce.sv
// Wake-pin debouncer: io_d must hold a new level for io_cfg_thresh+2 sampled
// cycles before io_level follows; qualified edges latch a sticky wake-pending flag.
//
// state     | meaning
// ----------+---------------------------------------------
// STABLE_LO | debounced level 0, io_d agrees
// CHK_HI    | io_d went high, counting stable cycles
// STABLE_HI | debounced level 1, io_d agrees
// CHK_LO    | io_d went low, counting stable cycles
import ux607_wake_pkg::*;

module ux607_wake_debounce #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_d,
  input  logic             io_cfg_en,
  input  logic [CNT_W-1:0] io_cfg_thresh,
  input  logic             io_cfg_rise_en,
  input  logic             io_cfg_fall_en,
  input  logic             io_clr,
  output logic             io_level,
  output logic             io_rise,
  output logic             io_fall,
  output logic             io_pend,
  output logic             io_irq
);

  wake_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             pend_q, pend_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    pend_d  = pend_q;

    if (!io_cfg_en) begin
      // Disabled: abandon any check and park on the side io_level already reports.
      state_d = level_q ? STABLE_HI : STABLE_LO;
      cnt_d   = '0;
    end else begin
      if ((rise_q && io_cfg_rise_en) || (fall_q && io_cfg_fall_en)) begin
        pend_d = 1'b1;
      end else if (io_clr) begin
        pend_d = 1'b0;
      end

      case (state_q)
        STABLE_LO: begin
          if (io_d) begin
            state_d = CHK_HI;
            cnt_d   = '0;
          end
        end
        CHK_HI: begin
          if (!io_d) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q >= io_cfg_thresh) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!io_d) begin
            state_d = CHK_LO;
            cnt_d   = '0;
          end
        end
        CHK_LO: begin
          if (io_d) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q >= io_cfg_thresh) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign io_level = level_q;
  assign io_rise  = rise_q;
  assign io_fall  = fall_q;
  assign io_pend  = pend_q;
  assign io_irq   = pend_q & io_cfg_en;

endmodule

// File: tb/tb_ux607_wake_debounce.sv
// Scoreboard bench for ux607_wake_debounce: a run-length reference model predicts
// every cycle's outputs; directed sequences add latency and corner-case checks.
module tb_ux607_wake_debounce;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_d, io_cfg_en, io_cfg_rise_en, io_cfg_fall_en, io_clr;
  logic [CNT_W-1:0] io_cfg_thresh;
  logic             io_level, io_rise, io_fall, io_pend, io_irq;

  ux607_wake_debounce #(.CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_d           (io_d),
    .io_cfg_en      (io_cfg_en),
    .io_cfg_thresh  (io_cfg_thresh),
    .io_cfg_rise_en (io_cfg_rise_en),
    .io_cfg_fall_en (io_cfg_fall_en),
    .io_clr         (io_clr),
    .io_level       (io_level),
    .io_rise        (io_rise),
    .io_fall        (io_fall),
    .io_pend        (io_pend),
    .io_irq         (io_irq)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected {level, rise, fall, pend, irq} after each rising edge, oldest first.
  logic [4:0] exp_q[$];

  // Reference model: level flips once io_d has disagreed with it for thresh+2
  // consecutive enabled edges (thresh read at the deciding edge).
  bit m_level, m_rise, m_fall, m_pend;
  int m_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit d, input bit en, input int th,
                      input bit re, input bit fe, input bit clr);
    @(negedge clock);
    reset          = rst;
    io_d           = d;
    io_cfg_en      = en;
    io_cfg_thresh  = th[CNT_W-1:0];
    io_cfg_rise_en = re;
    io_cfg_fall_en = fe;
    io_clr         = clr;
    if (!rst) begin
      m_level = 0; m_rise = 0; m_fall = 0; m_pend = 0; m_run = 0;
    end else begin
      bit np;
      np = m_pend;
      if (en) begin
        if ((m_rise && re) || (m_fall && fe)) np = 1;
        else if (clr) np = 0;
      end
      m_rise = 0;
      m_fall = 0;
      if (!en || d == m_level) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run >= th + 2) begin
          m_level = d;
          m_run   = 0;
          if (d) m_rise = 1;
          else   m_fall = 1;
        end
      end
      m_pend = np;
    end
    exp_q.push_back({m_level, m_rise, m_fall, m_pend, m_pend & en});
  endtask

  // Holds io_d at val; n = index of the first edge (1-based) after which io_level==val.
  task automatic run_until_level(input bit val, input int th, input bit re, input bit fe,
                                 input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step(1, val, 1, th, re, fe, 0);
      @(posedge clock);
      #2;
      if (io_level == val) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check($sformatf("cycle %0d {level,rise,fall,pend,irq}", cyc),
              {27'd0, io_level, io_rise, io_fall, io_pend, io_irq}, {27'd0, e});
      end
    end
  end

  initial begin : stim
    int n;
    bit rd, rre, rfe, ren, rclr;
    int rth;

    reset = 0; io_d = 0; io_cfg_en = 1; io_cfg_thresh = '0;
    io_cfg_rise_en = 0; io_cfg_fall_en = 0; io_clr = 0;
    m_level = 0; m_rise = 0; m_fall = 0; m_pend = 0; m_run = 0;
    #1;
    check("reset outputs before first edge",
          {io_level, io_rise, io_fall, io_pend, io_irq}, 5'b0);

    step(0, 0, 1, 3, 1, 1, 0);
    step(0, 0, 1, 3, 1, 1, 0);
    repeat (3) step(1, 0, 1, 3, 1, 1, 0);

    // thresh=3 rise: level and pulse on the 5th edge, pend follows
    run_until_level(1, 3, 1, 0, 20, n);
    check("rise latency thresh=3", n, 5);
    check("rise pulse with level", io_rise, 1);
    step(1, 1, 1, 3, 1, 0, 0);
    @(posedge clock); #2;
    check("pend after qualified rise", io_pend, 1);
    check("irq with pend and en", io_irq, 1);

    run_until_level(0, 3, 1, 0, 20, n);
    check("fall latency thresh=3", n, 5);
    step(1, 0, 1, 4, 1, 0, 1);
    @(posedge clock); #2;
    check("clr with unqualified fall", io_pend, 0);

    // thresh=4 bounce: 3 high cycles must not commit
    repeat (3) step(1, 1, 1, 4, 1, 1, 0);
    repeat (6) step(1, 0, 1, 4, 1, 1, 0);
    @(posedge clock); #2;
    check("bounce keeps level low", io_level, 0);
    check("bounce leaves pend", io_pend, 0);

    // set beats simultaneous clear
    run_until_level(1, 2, 1, 0, 20, n);
    check("rise latency thresh=2", n, 4);
    run_until_level(0, 2, 1, 1, 20, n);
    check("fall latency thresh=2", n, 4);
    check("fall pulse with level", io_fall, 1);
    step(1, 0, 1, 2, 1, 1, 1);
    @(posedge clock); #2;
    check("pend set wins over clr", io_pend, 1);
    step(1, 0, 1, 2, 1, 1, 1);
    @(posedge clock); #2;
    check("clr alone clears pend", io_pend, 0);

    // live threshold drop mid-check
    repeat (11) step(1, 1, 1, 100, 1, 0, 0);
    @(posedge clock); #2;
    check("no commit at thresh=100", io_level, 0);
    step(1, 1, 1, 5, 1, 0, 0);
    @(posedge clock); #2;
    check("commit after thresh lowered", {io_level, io_rise}, 2'b11);

    // disable during CHK_LO
    step(1, 1, 1, 3, 1, 0, 0);
    repeat (2) step(1, 0, 1, 3, 1, 1, 0);
    repeat (3) step(1, 0, 0, 3, 1, 1, 0);
    @(posedge clock); #2;
    check("disabled {level,fall,pend,irq}", {io_level, io_fall, io_pend, io_irq}, 4'b1010);
    step(1, 1, 1, 3, 1, 1, 0);
    @(posedge clock); #2;
    check("irq after re-enable", io_irq, 1);

    // async reset mid-CHK_HI with pend set
    run_until_level(0, 3, 0, 0, 20, n);
    check("fall latency before reset test", n, 5);
    repeat (3) step(1, 1, 1, 6, 1, 0, 0);
    @(posedge clock); #3;
    reset = 0;
    #1;
    check("async reset clears outputs",
          {io_level, io_rise, io_fall, io_pend, io_irq}, 5'b0);
    repeat (2) step(0, 1, 1, 6, 1, 0, 0);
    run_until_level(1, 6, 1, 0, 30, n);
    check("latency after reset release thresh=6", n, 8);

    // randomized phase
    rd = 1; rth = 2; rre = 1; rfe = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) rd = ~rd;
      if ($urandom_range(0, 49) == 0) begin
        rth = $urandom_range(0, 5);
        rre = 1'($urandom_range(0, 1));
        rfe = 1'($urandom_range(0, 1));
      end
      ren  = ($urandom_range(0, 29) != 0);
      rclr = ($urandom_range(0, 9) == 0);
      step(1, rd, ren, rth, rre, rfe, rclr);
    end

    repeat (2) @(posedge clock);
    #2;
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
